// File: rtl/lsu_port_arbiter.sv
// Shares the single LSU port between the memory stage and a debug/loader master.
// Debug wins immediately when the pipeline is idle, or after STARVE_MAX blocked cycles.
module lsu_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pipe_vld,
  input  logic        i_pipe_wren,
  input  logic [31:0] i_pipe_addr,
  input  logic [31:0] i_pipe_wdata,
  input  logic        i_dbg_req,
  input  logic        i_dbg_wren,
  input  logic [31:0] i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  input  logic [31:0] i_lsu_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_wdata,
  output logic        o_lsu_wren,
  output logic [31:0] o_pipe_rdata,
  output logic        o_stall_m,
  output logic        o_dbg_ack,
  output logic        o_dbg_rvalid,
  output logic [31:0] o_dbg_rdata
);

  typedef enum logic [1:0] {IDLE, DBG_ACC, DBG_RSP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic        dbg_ack_q;
  logic        dbg_rvalid_q;
  logic [31:0] dbg_rdata_q;
  logic        grant;

  assign grant = i_dbg_req & (~i_pipe_vld | (starve_cnt == STARVE_LIM));

  // The ack and rvalid flags are set on the edge entering the state they
  // describe, so they always coincide with DBG_ACC and DBG_RSP respectively.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      starve_cnt   <= 4'd0;
      dbg_ack_q    <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= 32'd0;
    end else begin
      dbg_ack_q    <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state      <= DBG_ACC;
            starve_cnt <= 4'd0;
            dbg_ack_q  <= 1'b1;
          end else if (!i_dbg_req) begin
            starve_cnt <= 4'd0;
          end else if (i_pipe_vld && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        DBG_ACC: begin
          state <= DBG_RSP;
          if (!i_dbg_wren) begin
            dbg_rdata_q  <= i_lsu_rdata;
            dbg_rvalid_q <= 1'b1;
          end
        end
        DBG_RSP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A pipeline store held during DBG_ACC is kept off the port; the frozen
  // memory stage presents it again in DBG_RSP.
  always_comb begin
    o_lsu_addr  = i_pipe_addr;
    o_lsu_wdata = i_pipe_wdata;
    o_lsu_wren  = i_pipe_vld & i_pipe_wren;
    o_stall_m   = 1'b0;
    if (state == DBG_ACC) begin
      o_lsu_addr  = i_dbg_addr;
      o_lsu_wdata = i_dbg_wdata;
      o_lsu_wren  = i_dbg_wren;
      o_stall_m   = i_pipe_vld;
    end
  end

  assign o_pipe_rdata = i_lsu_rdata;
  assign o_dbg_ack    = dbg_ack_q;
  assign o_dbg_rvalid = dbg_rvalid_q;
  assign o_dbg_rdata  = dbg_rdata_q;

endmodule

// File: doc/lsu_port_arbiter.md
LSU_PORT_ARBITER -- requirements
Module: lsu_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, range 1..15: number of consecutive pipeline-blocked cycles after which a pending debug request is forced through.
REQ-002 SHALL have ports, one per line:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pipe_vld  in  1  memory stage holds a valid load/store
- i_pipe_wren  in  1  memory-stage store enable
- i_pipe_addr  in  32  memory-stage address (ALU result)
- i_pipe_wdata  in  32  memory-stage store data
- i_dbg_req  in  1  debug/loader access request, level
- i_dbg_wren  in  1  debug store (1) / load (0)
- i_dbg_addr  in  32  debug address
- i_dbg_wdata  in  32  debug store data
- i_lsu_rdata  in  32  LSU combinational load data
- o_lsu_addr  out  32  LSU address
- o_lsu_wdata  out  32  LSU store data
- o_lsu_wren  out  1  LSU write enable
- o_pipe_rdata  out  32  load data to the pipeline (i_lsu_rdata pass-through)
- o_stall_m  out  1  freeze the memory stage and upstream stages
- o_dbg_ack  out  1  one-cycle pulse: debug access performed this cycle
- o_dbg_rvalid  out  1  one-cycle pulse: o_dbg_rdata valid
- o_dbg_rdata  out  32  registered debug load data

Function
REQ-003 SHALL implement a three-state FSM: IDLE, DBG_ACC, DBG_RSP.
REQ-004 In IDLE, the LSU SHALL be driven from the pipe inputs, with o_lsu_wren = i_pipe_vld & i_pipe_wren, and o_stall_m = 0.
REQ-005 In IDLE, the FSM SHALL go to DBG_ACC when i_dbg_req & (!i_pipe_vld | starve_cnt == STARVE_MAX); otherwise it stays in IDLE.
REQ-006 In DBG_ACC, the LSU SHALL be driven from the dbg inputs, with o_lsu_wren = i_dbg_wren; o_dbg_ack = 1; o_stall_m = i_pipe_vld (combinational); the next state SHALL be DBG_RSP unconditionally.
REQ-007 At the clock edge that ends DBG_ACC, o_dbg_rdata SHALL capture i_lsu_rdata on debug loads and hold its value on debug stores.
REQ-008 In DBG_RSP, the LSU SHALL return to the pipe inputs and o_stall_m = 0.
- o_dbg_rvalid = 1 only if the DBG_ACC access was a load.
- Next state IDLE unconditionally; at most one debug access per 3 cycles.
REQ-009 The 4-bit starve_cnt SHALL behave as follows:
- Increment in IDLE when i_dbg_req & i_pipe_vld, saturating at STARVE_MAX.
- Clear on entering DBG_ACC, and in IDLE when i_dbg_req = 0.
REQ-010 The debugger SHALL hold i_dbg_* stable from request until the o_dbg_ack cycle; the block SHALL sample them only in DBG_ACC.
REQ-011 Dropping i_dbg_req while in IDLE SHALL cancel the request with no access; dropping it in DBG_ACC or DBG_RSP SHALL NOT abort the access in progress.
REQ-012 A pipeline store stalled in DBG_ACC SHALL NOT reach the LSU (o_lsu_wren = i_dbg_wren only); the held memory stage SHALL replay it in DBG_RSP.
REQ-013 o_pipe_rdata SHALL equal i_lsu_rdata in all states; it is meaningful only when the pipeline owns the port.
REQ-014 Address and data SHALL pass through unmodified at full 32-bit width; the block SHALL do no alignment or decoding.

Reset
REQ-015 On reset assertion, asynchronously:
- state = IDLE, starve_cnt = 0, o_dbg_rdata = 0.
- o_dbg_ack = 0, o_dbg_rvalid = 0, o_stall_m = 0, o_lsu_wren = i_pipe_vld & i_pipe_wren.
REQ-016 Reset asserted during DBG_ACC or DBG_RSP SHALL abandon the access; no ack or rvalid SHALL be issued for it after release.
REQ-017 Outputs SHALL return to normal operation on the first rising edge after deassertion.

Verification
REQ-018 Idle port: i_pipe_vld = 0, debug load of addr 0x7000 with LSU data 0xCAFE0001 -> o_dbg_ack in cycle 1, o_dbg_rvalid with o_dbg_rdata = 0xCAFE0001 in cycle 2, o_stall_m = 0 throughout.
REQ-019 Starvation: i_pipe_vld held at 1, i_dbg_req raised at cycle 0, STARVE_MAX = 4 -> DBG_ACC in cycle 5, o_stall_m = 1 only in cycle 5, starve_cnt back to 0.
REQ-020 Store collision: pipeline store 0x11 to addr 0x100 during a debug store 0x22 to addr 0x200 in DBG_ACC -> only addr 0x200 written in that cycle; 0x100 written in DBG_RSP.
REQ-021 Cancel: i_dbg_req pulsed for 2 cycles while the pipeline is busy -> no ack, o_lsu_wren never driven by debug, starve_cnt = 0 afterwards.
REQ-022 Reset in DBG_ACC: i_rst_n low mid-cycle -> o_dbg_ack drops immediately, state IDLE, no rvalid after release.
REQ-023 Back-to-back debug requests with the pipeline idle -> acks spaced exactly 3 cycles apart.
